// File: rtl/rpsc_pkg.sv
// rpsc_pkg: shared definitions for the RPSC card 9 fault monitor.
//   NUM_FAULTS    number of latched-alarm lines from the card
//   FF17..FF24    bit index of each alarm line inside la_in / fault_vec_out
//   rpsc_state_e  monitor FSM state encoding (visible on state_out)
//   lowest_set    index of the lowest set bit, used for first-out capture
package rpsc_pkg;

    localparam int unsigned NUM_FAULTS = 8;

    localparam int unsigned FF17 = 0;  // G1_PS_Fault
    localparam int unsigned FF18 = 1;
    localparam int unsigned FF19 = 2;
    localparam int unsigned FF20 = 3;
    localparam int unsigned FF21 = 4;
    localparam int unsigned FF22 = 5;
    localparam int unsigned FF23 = 6;
    localparam int unsigned FF24 = 7;  // G2_PS_Internal_Fault

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'b00,
        ST_TRIPPED  = 2'b01,
        ST_CLEARING = 2'b10,
        ST_VERIFY   = 2'b11
    } rpsc_state_e;

    // Lowest index wins when several faults appear in the same cycle.
    function automatic logic [2:0] lowest_set(input logic [NUM_FAULTS-1:0] v);
        logic [2:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = FF17; i < NUM_FAULTS; i++) begin
            if (v[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rpsc_fault_monitor_if.sv
// rpsc_fault_monitor_if: signal bundle between the RPSC card 9 / interlock
// environment and the fault monitor.
//   la_in           [8]  latched alarm lines (asynchronous, active-high)
//   ack_in               operator acknowledge level (asynchronous)
//   trip_out             summary trip to the interlock chain
//   fault_vec_out   [8]  sticky debounced fault vector
//   first_valid_out      first_idx_out is valid
//   first_idx_out   [3]  first-out fault index
//   card_clear_out       latch-reset pulse to the card
//   state_out       [2]  monitor FSM state
// Modports: master = environment side, slave = monitor side.
interface rpsc_fault_monitor_if;
    import rpsc_pkg::*;

    logic [NUM_FAULTS-1:0] la_in;
    logic                  ack_in;
    logic                  trip_out;
    logic [NUM_FAULTS-1:0] fault_vec_out;
    logic                  first_valid_out;
    logic [2:0]            first_idx_out;
    logic                  card_clear_out;
    logic [1:0]            state_out;

    modport master (
        output la_in, ack_in,
        input  trip_out, fault_vec_out, first_valid_out, first_idx_out,
               card_clear_out, state_out
    );

    modport slave (
        input  la_in, ack_in,
        output trip_out, fault_vec_out, first_valid_out, first_idx_out,
               card_clear_out, state_out
    );

endinterface

// File: rtl/rpsc_debounce.sv
// rpsc_debounce: one alarm line -> 2-flop synchronizer -> symmetric debounce.
//   clk, reset   system clock, synchronous active-high reset
//   raw_in       asynchronous alarm line
//   db_out       debounced level
// The counter accumulates DEBOUNCE_CYCLES consecutive cycles of the opposite
// synchronized value; the new level is committed on the following edge if the
// input is still opposite. Any cycle matching db_out restarts the count.
module rpsc_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic db_out
);

    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            db_out <= 1'b0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            if (sync2 == db_out) begin
                cnt <= '0;
            end else if (cnt == DB_LIMIT) begin
                db_out <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/rpsc_fault_monitor.sv
// rpsc_fault_monitor: monitors the eight latched alarms of RPSC card 9,
// raises a summary trip, records a sticky fault vector and (optionally) the
// first-out fault, and runs the acknowledge / card-clear / verify sequence.
//   clk      system clock, rising edge
//   reset    synchronous, active-high
//   bus      rpsc_fault_monitor_if.slave (la_in, ack_in in; all status out)
// Parameters: DEBOUNCE_CYCLES (2..255), CLEAR_PULSE_CYCLES (1..15).
// Build option: define RPSC_FIRST_OUT_EN to enable first-out capture;
// otherwise first_valid_out / first_idx_out are tied to 0.
module rpsc_fault_monitor
    import rpsc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = 16,
    parameter int unsigned CLEAR_PULSE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rpsc_fault_monitor_if.slave  bus
);

    localparam logic [3:0] CLR_LAST = 4'(CLEAR_PULSE_CYCLES - 1);
    localparam logic [8:0] VER_LAST = 9'(DEBOUNCE_CYCLES + 1);

    logic [NUM_FAULTS-1:0] db_vec;

    genvar g;
    generate
        for (g = 0; g < NUM_FAULTS; g++) begin : g_db
            rpsc_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk    (clk),
                .reset  (reset),
                .raw_in (bus.la_in[g]),
                .db_out (db_vec[g])
            );
        end
    endgenerate

    // Acknowledge: synchronize, then detect the rising edge.
    logic ack_sync1;
    logic ack_sync2;
    logic ack_prev;
    logic ack_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_sync1 <= 1'b0;
            ack_sync2 <= 1'b0;
            ack_prev  <= 1'b0;
        end else begin
            ack_sync1 <= bus.ack_in;
            ack_sync2 <= ack_sync1;
            ack_prev  <= ack_sync2;
        end
    end

    assign ack_rise = ack_sync2 & ~ack_prev;

    rpsc_state_e           state,     state_nxt;
    logic [3:0]            clr_cnt,   clr_cnt_nxt;
    logic [8:0]            ver_cnt,   ver_cnt_nxt;
    logic [NUM_FAULTS-1:0] fault_vec, fault_vec_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_NORMAL;
            clr_cnt   <= '0;
            ver_cnt   <= '0;
            fault_vec <= '0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            ver_cnt   <= ver_cnt_nxt;
            fault_vec <= fault_vec_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clr_cnt_nxt   = clr_cnt;
        ver_cnt_nxt   = ver_cnt;
        fault_vec_nxt = fault_vec;
        case (state)
            ST_NORMAL: begin
                if (|db_vec) begin
                    state_nxt     = ST_TRIPPED;
                    fault_vec_nxt = db_vec;
                end
            end
            ST_TRIPPED: begin
                fault_vec_nxt = fault_vec | db_vec;
                if (ack_rise) begin
                    state_nxt   = ST_CLEARING;
                    clr_cnt_nxt = '0;
                end
            end
            ST_CLEARING: begin
                fault_vec_nxt = fault_vec | db_vec;
                if (clr_cnt == CLR_LAST) begin
                    state_nxt   = ST_VERIFY;
                    ver_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 4'd1;
                end
            end
            ST_VERIFY: begin
                fault_vec_nxt = fault_vec | db_vec;
                if (ver_cnt == VER_LAST) begin
                    if (|db_vec) begin
                        // Fault persisted through the clear: show only what is
                        // active now, keep the original first-out.
                        state_nxt     = ST_TRIPPED;
                        fault_vec_nxt = db_vec;
                    end else begin
                        state_nxt     = ST_NORMAL;
                        fault_vec_nxt = '0;
                    end
                end else begin
                    ver_cnt_nxt = ver_cnt + 9'd1;
                end
            end
            default: begin
                state_nxt = ST_NORMAL;
            end
        endcase
    end

    assign bus.state_out      = state;
    assign bus.trip_out       = (state != ST_NORMAL);
    assign bus.card_clear_out = (state == ST_CLEARING);
    assign bus.fault_vec_out  = fault_vec;

`ifdef RPSC_FIRST_OUT_EN
    // First-out is taken only on the NORMAL -> TRIPPED transition and is
    // released only when VERIFY returns to NORMAL.
    logic       first_valid;
    logic [2:0] first_idx;
    logic       capture_first;
    logic       clear_first;

    assign capture_first = (state == ST_NORMAL) && (|db_vec);
    assign clear_first   = (state == ST_VERIFY) && (state_nxt == ST_NORMAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            first_valid <= 1'b0;
            first_idx   <= '0;
        end else if (capture_first) begin
            first_valid <= 1'b1;
            first_idx   <= lowest_set(db_vec);
        end else if (clear_first) begin
            first_valid <= 1'b0;
            first_idx   <= '0;
        end
    end

    assign bus.first_valid_out = first_valid;
    assign bus.first_idx_out   = first_idx;
`else
    assign bus.first_valid_out = 1'b0;
    assign bus.first_idx_out   = '0;
`endif

endmodule

// File: tb/tb_rpsc_fault_monitor.sv
// Directed bench for rpsc_fault_monitor with DEBOUNCE_CYCLES=4,
// CLEAR_PULSE_CYCLES=3. Inputs change 1 ns after a rising edge, so the next
// rising edge is the sampling edge; outputs are sampled at the same point.
module tb_rpsc_fault_monitor;

`ifdef RPSC_FIRST_OUT_EN
    localparam bit FO = 1'b1;
`else
    localparam bit FO = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    rpsc_fault_monitor_if bus_if ();

    rpsc_fault_monitor #(
        .DEBOUNCE_CYCLES    (4),
        .CLEAR_PULSE_CYCLES (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic trip, input logic [7:0] vec,
                             input logic fv, input logic [2:0] fi,
                             input logic clr, input logic [1:0] st);
        check({tag, ".trip"},  32'(bus_if.trip_out),        32'(trip));
        check({tag, ".vec"},   32'(bus_if.fault_vec_out),   32'(vec));
        check({tag, ".fv"},    32'(bus_if.first_valid_out), 32'(fv & FO));
        check({tag, ".fi"},    32'(bus_if.first_idx_out),   FO ? 32'(fi) : 32'd0);
        check({tag, ".clr"},   32'(bus_if.card_clear_out),  32'(clr));
        check({tag, ".state"}, 32'(bus_if.state_out),       32'(st));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset          = 1'b1;
        bus_if.la_in   = 8'h00;
        bus_if.ack_in  = 1'b0;
        step(3);
        check_all("reset", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b00);
        reset = 1'b0;
        step(2);

        // Single fault on bit 2: trip exactly 7 edges after the sampling edge.
        bus_if.la_in = 8'h04;
        step(7);
        check_all("lat_pre", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b00);
        step(1);
        check_all("lat_trip", 1'b1, 8'h04, 1'b1, 3'd2, 1'b0, 2'b01);

        // Release, then acknowledge: 3 cycles CLEARING, 6 cycles VERIFY, NORMAL.
        bus_if.la_in = 8'h00;
        step(10);
        check_all("sticky", 1'b1, 8'h04, 1'b1, 3'd2, 1'b0, 2'b01);
        bus_if.ack_in = 1'b1;
        step(2);
        check("ack_lat.state", 32'(bus_if.state_out), 32'd1);
        step(1);
        check_all("clr0", 1'b1, 8'h04, 1'b1, 3'd2, 1'b1, 2'b10);
        bus_if.ack_in = 1'b0;
        for (int i = 1; i < 3; i++) begin
            step(1);
            check_all($sformatf("clr%0d", i), 1'b1, 8'h04, 1'b1, 3'd2, 1'b1, 2'b10);
        end
        for (int i = 0; i < 6; i++) begin
            step(1);
            check_all($sformatf("ver%0d", i), 1'b1, 8'h04, 1'b1, 3'd2, 1'b0, 2'b11);
            // A new ack edge arriving during VERIFY must not be remembered.
            if (i == 1) bus_if.ack_in = 1'b1;
        end
        step(1);
        check_all("norm", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b00);
        step(6);
        check_all("no_queue", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b00);
        bus_if.ack_in = 1'b0;
        step(3);

        // Three-cycle glitch on bit 0 is filtered out.
        bus_if.la_in = 8'h01;
        step(3);
        bus_if.la_in = 8'h00;
        step(12);
        check_all("glitch", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b00);

        // Simultaneous faults 3 and 7: lowest index wins first-out.
        bus_if.la_in = 8'h88;
        step(8);
        check_all("simul", 1'b1, 8'h88, 1'b1, 3'd3, 1'b0, 2'b01);

        // Bit 5 appears while tripped and stays through the clear sequence.
        bus_if.la_in = 8'h20;
        step(10);
        check_all("or_in", 1'b1, 8'ha8, 1'b1, 3'd3, 1'b0, 2'b01);
        bus_if.ack_in = 1'b1;
        step(11);
        check_all("ver_last", 1'b1, 8'ha8, 1'b1, 3'd3, 1'b0, 2'b11);
        step(1);
        check_all("retrip", 1'b1, 8'h20, 1'b1, 3'd3, 1'b0, 2'b01);

        // Reset in the middle of CLEARING.
        bus_if.ack_in = 1'b0;
        step(3);
        bus_if.ack_in = 1'b1;
        step(4);
        check_all("pre_rst", 1'b1, 8'h20, 1'b1, 3'd3, 1'b1, 2'b10);
        reset        = 1'b1;
        bus_if.la_in = 8'h00;
        step(1);
        check_all("rst_mid", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b00);
        step(2);
        reset = 1'b0;
        step(10);
        check_all("post_rst", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rpsc_fault_monitor.md
RPSC_FAULT_MONITOR -- requirements
Module: rpsc_fault_monitor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable synchronized cycles before a fault bit changes (range 2..255).
REQ-002 Parameter CLEAR_PULSE_CYCLES, default 4, width of card_clear_out pulse (range 1..15).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 la_in  in  8  asynchronous latched-alarm lines from RPSC card 9; bit0=FF17 G1_PS_Fault ... bit7=FF24 G2_PS_Internal_Fault; active-high.
REQ-006 ack_in  in  1  operator acknowledge level, asynchronous; only its synchronized rising edge is used.
REQ-007 trip_out  out  1  summary trip to interlock chain.
REQ-008 fault_vec_out  out  8  captured debounced faults, sticky until cleared.
REQ-009 first_valid_out  out  1  first_idx_out holds a valid first-out fault.
REQ-010 first_idx_out  out  3  index of the first fault captured since last clear.
REQ-011 card_clear_out  out  1  pulse that resets card 9 alarm latches.
REQ-012 state_out  out  2  current FSM state encoding.

Function
REQ-013 Each la_in bit and ack_in SHALL pass a 2-flop synchronizer before any use.
REQ-014 Each fault bit SHALL debounce symmetrically: debounced value changes only after DEBOUNCE_CYCLES consecutive cycles of opposite synchronized value; any glitch restarts the count.
REQ-015 Latency: la_in bit high sampled at edge N with no prior fault SHALL give fault_vec_out bit and trip_out high at edge N+DEBOUNCE_CYCLES+3.
REQ-016 FSM states: NORMAL=00, TRIPPED=01, CLEARING=10, VERIFY=11.
REQ-017 NORMAL: any debounced bit high -> TRIPPED; ack edges ignored.
REQ-018 TRIPPED: fault_vec_out ORs in every debounced bit each cycle; ack rising edge -> CLEARING.
REQ-019 CLEARING: card_clear_out high exactly CLEAR_PULSE_CYCLES cycles, then -> VERIFY.
REQ-020 VERIFY: wait DEBOUNCE_CYCLES+2 cycles; if any debounced bit high at expiry -> TRIPPED with fault_vec_out reloaded to current debounced bits, first-out unchanged; else -> NORMAL, clearing fault_vec_out, first_valid_out, first_idx_out.
REQ-021 trip_out SHALL equal 1 in TRIPPED, CLEARING, VERIFY; 0 in NORMAL.
REQ-022 Ack edges in CLEARING or VERIFY SHALL be ignored, not queued.
REQ-023 Simultaneous new faults in one cycle: first_idx_out takes the lowest index.
REQ-024 Faults arising during CLEARING/VERIFY SHALL be OR-ed into fault_vec_out but not alter first-out.

Reset
REQ-025 Reset SHALL force NORMAL, all outputs 0, synchronizers, debounce counters and debounced values 0.
REQ-026 Reset mid-CLEARING SHALL drop card_clear_out on the next edge.

Configuration
REQ-027 RPSC_FIRST_OUT_EN defined: first-out capture per REQ-009/010/023.
REQ-028 RPSC_FIRST_OUT_EN undefined: first_valid_out and first_idx_out tied 0, no first-out registers.

Structure
REQ-029 Package rpsc_pkg SHALL hold NUM_FAULTS=8, fault index constants FF17..FF24, and the FSM state enum.
REQ-030 Sub-module rpsc_debounce (one-bit synchronizer plus debounce counter), instanced per fault bit.

Verification (DEBOUNCE_CYCLES=4, CLEAR_PULSE_CYCLES=3)
REQ-031 la_in=8'h04 held from edge 10 -> trip_out, fault_vec_out=8'h04 at edge 17; first_idx_out=2.
REQ-032 la_in bit0 pulses high 3 cycles -> no trip, fault_vec_out stays 8'h00.
REQ-033 la_in=8'h88 same cycle -> first_idx_out=3, fault_vec_out=8'h88.
REQ-034 Trip, la_in released, ack edge -> card_clear_out high 3 cycles, VERIFY 6 cycles, NORMAL, all outputs 0.
REQ-035 Trip, ack with la_in bit5 still high -> after VERIFY back to TRIPPED, fault_vec_out=8'h20, first-out retained.
REQ-036 Reset asserted during CLEARING -> next edge card_clear_out=0, state_out=00, all outputs 0.
